// File: rtl/compute_core_simt.sv
// SIMT compute core: NUM_THREADS threads share one fixed ROM and one ALU.
// Round-robin issue of one instruction per clock; define CORE_TRACE_EN for a per-issue trace.
module compute_core_simt #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_THREADS = 4,
    parameter int REG_COUNT   = 16,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic clk,
    input  logic reset,
    output logic halt
);

    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_TID  = 4'h9;
    localparam logic [3:0] OP_BNZ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic [15:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
        case (a)
            ADDR_WIDTH'(0): rom_word = 16'h9100;
            ADDR_WIDTH'(1): rom_word = 16'h7203;
            ADDR_WIDTH'(2): rom_word = 16'h7401;
            ADDR_WIDTH'(3): rom_word = 16'h1331;
            ADDR_WIDTH'(4): rom_word = 16'h2224;
            ADDR_WIDTH'(5): rom_word = 16'hA023;
            default:        rom_word = 16'hF000;
        endcase
    endfunction

    logic [ADDR_WIDTH-1:0] pc     [0:NUM_THREADS-1];
    logic [DATA_WIDTH-1:0] regs   [0:NUM_THREADS-1][0:REG_COUNT-1];
    logic [NUM_THREADS-1:0] halted;
    logic [TW-1:0]          sched;

    logic [15:0]            instr;
    logic [3:0]             op, rd, rs, rt;
    logic [DATA_WIDTH-1:0]  rs_val, rt_val;
    logic                   issue;
    logic                   wb_en;
    logic [DATA_WIDTH-1:0]  wb_val;
    logic [ADDR_WIDTH-1:0]  pc_d;
    logic [NUM_THREADS-1:0] halted_d;
    logic [TW-1:0]          sched_d;

    assign instr  = rom_word(pc[sched]);
    assign op     = instr[15:12];
    assign rd     = instr[11:8];
    assign rs     = instr[7:4];
    assign rt     = instr[3:0];
    assign rs_val = regs[sched][rs];
    assign rt_val = regs[sched][rt];
    assign issue  = ~&halted;
    assign halt   = &halted;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wb_en    = 1'b0;
        wb_val   = '0;
        pc_d     = pc[sched] + ADDR_WIDTH'(1);
        halted_d = halted;
        case (op)
            OP_ADD:  begin wb_en = 1'b1; wb_val = rs_val + rt_val; end
            OP_SUB:  begin wb_en = 1'b1; wb_val = rs_val - rt_val; end
            OP_MUL:  begin wb_en = 1'b1; wb_val = rs_val * rt_val; end
            OP_AND:  begin wb_en = 1'b1; wb_val = rs_val & rt_val; end
            OP_OR:   begin wb_en = 1'b1; wb_val = rs_val | rt_val; end
            OP_XOR:  begin wb_en = 1'b1; wb_val = rs_val ^ rt_val; end
            OP_LDI:  begin wb_en = 1'b1; wb_val = DATA_WIDTH'(instr[7:0]); end
            OP_ADDI: begin wb_en = 1'b1; wb_val = rs_val + DATA_WIDTH'(rt); end
            OP_TID:  begin wb_en = 1'b1; wb_val = DATA_WIDTH'(sched); end
            OP_BNZ:  if (rs_val != '0) pc_d = ADDR_WIDTH'(rt);
            OP_JMP:  pc_d = ADDR_WIDTH'(rt);
            OP_HALT: begin pc_d = pc[sched]; halted_d[sched] = 1'b1; end
            default: ;
        endcase
    end

    // Next issuer is the first thread after sched that is still running once this edge's HALT lands.
    always_comb begin
        int  cand;
        logic found;
        sched_d = sched;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            cand = (int'(sched) + k) % NUM_THREADS;
            if (!found && !halted_d[cand]) begin
                sched_d = TW'(cand);
                found   = 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the register files are reset explicitly because a mid-run reset must rerun the program from all-zero state.
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc[t] <= '0;
                for (int r = 0; r < REG_COUNT; r++) regs[t][r] <= '0;
            end
            halted <= '0;
            sched  <= '0;
        end else if (issue) begin
            if (wb_en) regs[sched][rd] <= wb_val;
            pc[sched] <= pc_d;
            halted    <= halted_d;
            sched     <= sched_d;
        end
    end

`ifdef CORE_TRACE_EN
    always @(posedge clk) begin
        if (reset && issue) begin
            if (wb_en)
                $display("%0t: thread %0d pc %0d instr %h wb r%0d=%0h", $time, sched, pc[sched], instr, rd, wb_val);
            else
                $display("%0t: thread %0d pc %0d instr %h", $time, sched, pc[sched], instr);
            if (&halted_d)
                $display("%0t: all threads halted", $time);
        end
    end
`endif

endmodule

// File: tb/tb_compute_core_simt.sv
// Bench for compute_core_simt: stimulus queues expected state per edge count; a negedge monitor pops and compares.
module tb_compute_core_simt;

    logic clk;
    logic reset;
    logic halt;

    compute_core_simt dut (
        .clk   (clk),
        .reset (reset),
        .halt  (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;   // 0 halt, 1 pc[idx], 2 regs[idx/16][idx%16], 3 halted vector
        int          idx;
        logic [63:0] exp_v;
        string       name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int tick = 0;
    int base = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) tick <= tick + 1;

    function automatic logic [63:0] probe(input int kind, input int idx);
        case (kind)
            0: probe = 64'(halt);
            1: probe = 64'(dut.pc[idx]);
            2: probe = dut.regs[idx / 16][idx % 16];
            3: probe = 64'(dut.halted);
            default: probe = '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    sb_entry_t e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= tick) begin
            e = sb.pop_front();
            if (e.cyc < tick) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: sample missed at tick %0d, wanted %0d", e.name, tick, e.cyc);
            end else begin
                check(e.name, probe(e.kind, e.idx), e.exp_v);
            end
        end
    end

    task automatic expect_at(input int k, input int kind, input int idx, input logic [63:0] v, input string name);
        sb_entry_t x;
        x.cyc = base + k; x.kind = kind; x.idx = idx; x.exp_v = v;
        x.name = $sformatf("%s@%0d", name, k);
        sb.push_back(x);
    endtask

    task automatic do_reset(input int edges);
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (edges) @(posedge clk);
        #2;
        reset = 1'b1;
        base = tick;
    endtask

    task automatic push_start();
        expect_at(0, 0, 0, 64'd0, "halt_rst");
        expect_at(0, 3, 0, 64'h0, "halted_rst");
        for (int t = 0; t < 4; t++) begin
            expect_at(0, 1, t, 64'd0, $sformatf("pc%0d_rst", t));
            for (int r = 1; r < 4; r++)
                expect_at(0, 2, t * 16 + r, 64'd0, $sformatf("r%0d_t%0d_rst", r, t));
        end
        for (int t = 0; t < 4; t++) begin
            expect_at(4, 1, t, 64'd1, $sformatf("pc%0d", t));
            expect_at(4, 2, t * 16 + 1, 64'(t), $sformatf("tid_t%0d", t));
        end
        expect_at(5, 1, 0, 64'd2, "pc0_stagger");
        for (int t = 1; t < 4; t++)
            expect_at(5, 1, t, 64'd1, $sformatf("pc%0d_stagger", t));
    endtask

    task automatic push_end(input int k);
        expect_at(k, 0, 0, 64'd1, "halt");
        expect_at(k, 3, 0, 64'hF, "halted");
        for (int t = 0; t < 4; t++) begin
            expect_at(k, 1, t, 64'd6, $sformatf("pc%0d_end", t));
            expect_at(k, 2, t * 16 + 3, 64'(3 * t), $sformatf("r3_t%0d", t));
            expect_at(k, 2, t * 16 + 2, 64'd0, $sformatf("r2_t%0d", t));
        end
    endtask

    initial begin
        reset = 1'b0;

        // Full run, then 20 idle edges after halt.
        do_reset(2);
        push_start();
        expect_at(51, 0, 0, 64'd0, "halt_early");
        push_end(52);
        push_end(72);
        repeat (72) @(posedge clk);
        #2;

        // Reset from halted state, then reset again mid-program.
        do_reset(1);
        push_start();
        expect_at(30, 0, 0, 64'd0, "halt_mid");
        expect_at(30, 1, 0, 64'd5, "pc0_mid");
        expect_at(30, 1, 3, 64'd4, "pc3_mid");
        expect_at(30, 2, 0 * 16 + 2, 64'd1, "r2_t0_mid");
        expect_at(30, 2, 3 * 16 + 2, 64'd2, "r2_t3_mid");
        expect_at(30, 2, 3 * 16 + 3, 64'd6, "r3_t3_mid");
        repeat (30) @(posedge clk);
        #2;

        do_reset(1);
        push_start();
        expect_at(51, 0, 0, 64'd0, "halt_early_rerun");
        push_end(52);
        repeat (52) @(posedge clk);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/compute_core_simt.md
Name: compute_core_simt

Overview:
- Small SIMT-style compute core: NUM_THREADS hardware threads share one built-in instruction ROM and one ALU.
- Each thread has its own PC and register file.
- A round-robin scheduler issues one instruction per clock from one non-halted thread.
- `halt` rises when every thread has executed HALT. Leaf block of the GPU datapath, used standalone in core-level benches.

Parameters:
DATA_WIDTH, 64, register/ALU width in bits
NUM_THREADS, 4, number of hardware threads (scheduler index width = clog2(NUM_THREADS), min 1)
REG_COUNT, 16, registers per thread (4-bit register specifiers)
ADDR_WIDTH, 4, PC/ROM address width; ROM depth 2^ADDR_WIDTH, 16-bit instruction words

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-low (asserted when 0): state cleared on a rising edge that samples reset=0
halt  output  1  1 when all threads are halted

Behaviour:
- Required internal state names (benches probe them hierarchically): `pc[0:NUM_THREADS-1]` (ADDR_WIDTH bits each), `regs[thread][reg]` (DATA_WIDTH bits), `halted[NUM_THREADS-1:0]`, `sched` (currently issuing thread).
- Reset clears all of the following: pc, regs, halted, sched to 0. `halt` reads 0 after the reset edge. Reset mid-run behaves identically and restarts the program from pc 0.
- Issue: each non-reset edge executes `rom[pc[sched]]` for thread `sched`, single cycle, with writeback and pc update on the same edge.
- `sched` then advances to the next non-halted thread in circular order (sched+1, sched+2, …). A halted thread is never issued.
- If all threads are halted, nothing changes.
- Instruction format: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
- pc advances to pc+1 mod 2^ADDR_WIDTH (15 wraps to 0) unless stated otherwise. Arithmetic wraps modulo 2^DATA_WIDTH.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rs+rt.
  - 2 SUB: rd=rs-rt.
  - 3 MUL: rd=low DATA_WIDTH bits of rs*rt.
  - 4 AND, 5 OR, 6 XOR.
  - 7 LDI: rd=zero-extended [7:0].
  - 8 ADDI: rd=rs+zero-extended imm4.
  - 9 TID: rd=thread index.
  - A BNZ: if rs!=0 then pc=imm4, else pc+1.
  - B JMP: pc=imm4.
  - F HALT: set halted[t]; pc unchanged.
  - C, D, E execute as NOP.
- All 16 registers are general purpose; r0 is not hardwired.
- `halt` = AND of `halted`, combinational from flops, so it rises right after the edge that executes the last HALT.
- Default ROM (fixed contents):
  - 0:9100 TID r1
  - 1:7203 LDI r2,3
  - 2:7401 LDI r4,1
  - 3:1331 ADD r3,r3,r1
  - 4:2224 SUB r2,r2,r4
  - 5:A023 BNZ r2→3
  - 6..15:F000 HALT
- Default program behaviour: each thread executes 13 instructions and ends with r3=3·tid, r2=0, pc=6.

Optional Feature:
- Macro CORE_TRACE_EN.
- Defined: on each issuing edge, simulation `$display` of time, thread, pc, instruction word, and writeback value (if any). On the edge where halt first rises, one "all threads halted" line.
- Undefined: no display code compiled. Functional behaviour identical in both cases.

Test Plan:
- Hold reset=0 for 2 edges, then release → pc[0..3]=0, halt=0, all regs 0.
- 4 edges after release → each thread issued once in order 0,1,2,3; pc[0..3]=1; regs[t][1]=t.
- Run 52 edges after release → halt rises immediately after edge 52 (not after edge 51); pc all =6; regs[t][3]=0,3,6,9; regs[t][2]=0.
- Keep clocking 20 more edges after halt → no state change, halt stays 1.
- Assert reset=0 for one edge while halt=1 (or mid-program, e.g. after edge 30) → next state all zero, halt=0; program reruns and halt rises again 52 edges after release.
- Stagger check: after edge 5 only thread 0 is at pc=2, threads 1..3 at pc=1 → confirms round-robin order and single issue per cycle.
